rv32i_trace_buf: RTL

- Synthesisable, parametrised commit-trace capture buffer for the RV32I core.
- Records one entry per retired instruction: PC, destination register, write-enable and writeback data.
- Entries go into a DEPTH-entry on-chip buffer, under fill-stop or PC-trigger mode; the buffer is then drained over a valid/ready stream.
- Sits beside RV32I_TOP and taps the writeback stage, replacing simulation-only register/PC monitoring with hardware-observable trace.

---
 rtl/rv32i_trace_buf.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv32i_trace_buf.sv
// rv32i_trace_buf: commit-trace capture buffer for the RV32I core.
//
// Taps the writeback stage and records one entry {pc, rd, we, wdata} per
// retired instruction into a DEPTH-entry circular buffer. Two capture modes:
//   mode 0 (fill-stop)  : record until the buffer is full, then freeze.
//   mode 1 (PC-trigger) : record circularly (oldest entry overwritten) until
//                         a commit at trig_pc, then POST_TRIG more, then freeze.
// Once frozen (DONE) the buffer is drained oldest-first over a valid/ready
// stream; accepting the last entry returns the block to IDLE.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   mode, arm, clear  capture mode (sampled on arm), start pulse, abort pulse
//   trig_pc           trigger PC (sampled on arm)
//   commit_*          retirement tap: valid, pc, rd, we, wdata
//   rd_valid/ready    readout handshake, rd_data = {pc, rd, we, wdata}
//   count             entries currently held
//   state             00 IDLE, 01 PRE, 10 POST, 11 DONE
//   wrapped           an entry was overwritten during this capture
//   triggered         the trigger fired during this capture
module rv32i_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int RA_W      = 5,
  parameter int POST_TRIG = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic                             arm,
  input  logic                             clear,
  input  logic [PC_W-1:0]                  trig_pc,
  input  logic                             commit_valid,
  input  logic [PC_W-1:0]                  commit_pc,
  input  logic [RA_W-1:0]                  commit_rd,
  input  logic                             commit_we,
  input  logic [DATA_W-1:0]                commit_wdata,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [PC_W+RA_W+1+DATA_W-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]           count,
  output logic [1:0]                       state,
  output logic                             wrapped,
  output logic                             triggered
);

  localparam int ENTRY_W = PC_W + RA_W + 1 + DATA_W;
  localparam int PTR_W   = $clog2(DEPTH);

  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_LAST  = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] POST_LAST = (PTR_W+1)'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    POST = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q;
  logic [PC_W-1:0]    trig_pc_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     post_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic rec;        // record the current commit
  logic overwrite;  // recording into a full buffer drops the oldest entry
  logic trig_hit;   // this commit fires the trigger
  logic pop;        // consumer accepts the head entry
  logic start;      // arm accepted in IDLE

  always_comb begin
    start     = !clear && arm && (state_q == IDLE);
    rec       = !clear && commit_valid && ((state_q == PRE) || (state_q == POST));
    overwrite = rec && (count == CNT_FULL);
    trig_hit  = rec && (state_q == PRE) && mode_q && !triggered &&
                (commit_pc == trig_pc_q);
    rd_valid  = (state_q == DONE) && (count != '0);
    pop       = !clear && rd_valid && rd_ready;
    rd_data   = mem[rd_ptr];
    state     = state_q;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (arm) state_d = PRE;
        PRE: begin
          if (rec) begin
            if (!mode_q) begin
              if (count == CNT_LAST) state_d = DONE;
            end else if (trig_hit) begin
              state_d = (POST_TRIG == 0) ? DONE : POST;
            end
          end
        end
        POST: if (rec && ((post_cnt + 1'b1) == POST_LAST)) state_d = DONE;
        DONE: if (pop && (count == (PTR_W+1)'(1))) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      trig_pc_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear || start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        post_cnt  <= '0;
        wrapped   <= 1'b0;
        triggered <= 1'b0;
        if (start) begin
          mode_q    <= mode;
          trig_pc_q <= trig_pc;
        end
      end else begin
        if (rec) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (overwrite) begin
            // Full circular buffer: the oldest entry is lost, count holds.
            rd_ptr  <= rd_ptr + 1'b1;
            wrapped <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
          if (trig_hit) begin
            triggered <= 1'b1;
            post_cnt  <= '0;
          end else if (state_q == POST) begin
            post_cnt <= post_cnt + 1'b1;
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
      end
    end
  end

  // Trace storage carries no reset; stale contents are never visible
  // because rd_valid requires a non-zero count.
  always_ff @(posedge clk) begin
    if (rec) mem[wr_ptr] <= {commit_pc, commit_rd, commit_we, commit_wdata};
  end

endmodule
